// File: rtl/tile_multiply.sv
// rtl/tile_multiply.sv - signed fixed-point tile multiply (A[MxK] * B[KxN]) on one shared MAC; TILE_MUL_SAT_EN selects saturating narrowing
module tile_multiply #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int TILE_M = 2,
  parameter int TILE_K = 2,
  parameter int TILE_N = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [TILE_M*TILE_K*DATA_W-1:0]  tile_a,
  input  logic [TILE_K*TILE_N*DATA_W-1:0]  tile_b,
  output logic                             busy,
  output logic                             done,
  output logic [TILE_M*TILE_N*DATA_W-1:0]  tile_c
);

  localparam int ACC_W = 2*DATA_W + $clog2(TILE_K);
  localparam int IW    = (TILE_M > 1) ? $clog2(TILE_M) : 1;
  localparam int JW    = (TILE_N > 1) ? $clog2(TILE_N) : 1;
  localparam int KW    = (TILE_K > 1) ? $clog2(TILE_K) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(TILE_M-1);
  localparam logic [JW-1:0] J_LAST = JW'(TILE_N-1);
  localparam logic [KW-1:0] K_LAST = KW'(TILE_K-1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] a_mem [TILE_M][TILE_K];
  logic signed [DATA_W-1:0] b_mem [TILE_K][TILE_N];
  logic        [DATA_W-1:0] c_mem [TILE_M][TILE_N];

  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [2*DATA_W-1:0] prod;
  logic        [DATA_W-1:0]   c_fmt;

  logic accept;
  logic mac_en;
  logic i_last;
  logic j_last;
  logic k_last;

`ifdef TILE_MUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;
`endif

  assign i_last = (i == I_LAST);
  assign j_last = (j == J_LAST);
  assign k_last = (k == K_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus status outputs and datapath enables
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (i_last && j_last && k_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-precision MAC step and the fixed-point narrowing of its result
  always_comb begin
    prod     = a_mem[i][k] * b_mem[k][j];
    acc_next = acc + ACC_W'(prod);
`ifdef TILE_MUL_SAT_EN
    shifted = acc_next >>> FRAC_W;
    if (shifted > SAT_MAX)      c_fmt = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN) c_fmt = {1'b1, {(DATA_W-1){1'b0}}};
    else                        c_fmt = shifted[DATA_W-1:0];
`else
    c_fmt = DATA_W'(acc_next >>> FRAC_W);
`endif
  end

  // Operand capture on accept, then walk (i, j, k) with k innermost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < TILE_M; r++)
        for (int c = 0; c < TILE_K; c++) a_mem[r][c] <= '0;
      for (int r = 0; r < TILE_K; r++)
        for (int c = 0; c < TILE_N; c++) b_mem[r][c] <= '0;
      for (int r = 0; r < TILE_M; r++)
        for (int c = 0; c < TILE_N; c++) c_mem[r][c] <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (accept) begin
      for (int r = 0; r < TILE_M; r++)
        for (int c = 0; c < TILE_K; c++)
          a_mem[r][c] <= tile_a[(r*TILE_K+c)*DATA_W +: DATA_W];
      for (int r = 0; r < TILE_K; r++)
        for (int c = 0; c < TILE_N; c++)
          b_mem[r][c] <= tile_b[(r*TILE_N+c)*DATA_W +: DATA_W];
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else if (mac_en) begin
      if (k_last) begin
        c_mem[i][j] <= c_fmt;
        acc         <= '0;
        k           <= '0;
        if (j_last) begin
          j <= '0;
          i <= i_last ? '0 : i + IW'(1);
        end else begin
          j <= j + JW'(1);
        end
      end else begin
        acc <= acc_next;
        k   <= k + KW'(1);
      end
    end
  end

  // Pack the result array back into the row-major output bus
  always_comb begin
    tile_c = '0;
    for (int r = 0; r < TILE_M; r++)
      for (int c = 0; c < TILE_N; c++)
        tile_c[(r*TILE_N+c)*DATA_W +: DATA_W] = c_mem[r][c];
  end

endmodule
